// File: rtl/fb_vga_scanout.sv
// ---------------------------------------------------------------------------
// fb_vga_scanout
//
// Scans the 320x240 RGB332 result frame buffer out to a 640x480@60 VGA
// monitor, showing every buffer pixel as a 2x2 block. The block produces the
// VGA timing, presents synchronous-RAM read addresses, and delays sync,
// blanking and display enable to match the RAM read latency. All pins then
// leave the block RD_LAT+1 clocks after the counter state that produced them.
//
// Ports:
//   clk        in   25 MHz pixel clock
//   reset      in   asynchronous, active-low reset
//   rd_en      out  RAM read strobe, high while the addressed pixel is visible
//   rd_addr    out  [16:0] frame-buffer read address (holds while blanking)
//   rd_data    in   [7:0] RAM read data, valid RD_LAT clocks after rd_addr
//   hsync      out  horizontal sync, active-low
//   vsync      out  vertical sync, active-low
//   de         out  display enable, aligned with pix
//   pix        out  [7:0] RGB332 pixel to the DAC, 0 while de=0
//   frame_done out  one-clock pulse on the clock after the last visible
//                   pixel of the frame is requested
// ---------------------------------------------------------------------------
module fb_vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 320,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rd_en,
  output logic [16:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  pix,
  output logic        frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DEPTH   = RD_LAT + 1;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0]  V_ACT_M1  = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  HS_FIRST  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [16:0] LINE_STEP = 17'(IMG_W);

  // Counter state (stage 0)
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [16:0] line_base_q, line_base_d;
  logic [16:0] addr_hold_q, addr_hold_d;

  // Delay lines for the stage-0 timing bits; index DEPTH-1 drives the pins
  logic [DEPTH-1:0] active_pipe_q, active_pipe_d;
  logic [DEPTH-1:0] hs_pipe_q, hs_pipe_d;
  logic [DEPTH-1:0] vs_pipe_q, vs_pipe_d;
  logic [7:0]       pix_q, pix_d;

  logic active_raw;
  logic hsync_raw;
  logic vsync_raw;
  logic h_wrap;
  logic v_wrap;

  // NOTE: every signal assigned in this always_comb gets a default before any
  // conditional assignment, so no path leaves a value unassigned and no latch
  // is inferred.
  always_comb begin
    active_raw  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync_raw   = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    vsync_raw   = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    h_wrap      = (h_cnt_q == H_LAST);
    v_wrap      = (v_cnt_q == V_LAST);

    h_cnt_d     = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d     = v_cnt_q;
    line_base_d = line_base_q;

    if (h_wrap) begin
      if (v_wrap) begin
        v_cnt_d     = 10'd0;
        line_base_d = 17'd0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
        // Each buffer row is shown on two display lines; advance the row base
        // only after the second (odd) line of the pair.
        if (v_cnt_q[0] && (v_cnt_q < V_ACT)) begin
          line_base_d = line_base_q + LINE_STEP;
        end
      end
    end

    // Horizontal doubling: two adjacent display pixels share a buffer column.
    rd_addr     = active_raw ? (line_base_q + {8'd0, h_cnt_q[9:1]}) : addr_hold_q;
    addr_hold_d = rd_addr;

    // The counters sit at (0,0) during reset, which is a visible position;
    // qualifying with reset keeps the strobe low while the block is held.
    rd_en       = active_raw && reset;

    frame_done  = (h_cnt_q == H_ACT) && (v_cnt_q == V_ACT_M1);

    active_pipe_d = {active_pipe_q[DEPTH-2:0], active_raw};
    hs_pipe_d     = {hs_pipe_q[DEPTH-2:0], hsync_raw};
    vs_pipe_d     = {vs_pipe_q[DEPTH-2:0], vsync_raw};

    // rd_data answers the address presented RD_LAT clocks ago; the matching
    // active bit sits one stage before the output stage at this moment.
    pix_d = active_pipe_q[DEPTH-2] ? rd_data : 8'h00;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      line_base_q   <= 17'd0;
      addr_hold_q   <= 17'd0;
      active_pipe_q <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      pix_q         <= 8'h00;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_base_q   <= line_base_d;
      addr_hold_q   <= addr_hold_d;
      active_pipe_q <= active_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      pix_q         <= pix_d;
    end
  end

  assign de    = active_pipe_q[DEPTH-1];
  assign hsync = hs_pipe_q[DEPTH-1];
  assign vsync = vs_pipe_q[DEPTH-1];
  assign pix   = pix_q;

endmodule
